lsu_mem_ctrl: RTL

Multi-cycle load/store controller sitting between the execute stage and the data memory.
- Drives data memory with a req/ack handshake: sub-word byte enables, lane-replicated store data.
- Aligns and sign/zero-extends returned load data, then presents it as data_mem to the writeback select.
- Stalls the pipeline while an access is outstanding.

---
 rtl/lsu_mem_if.sv | 24 ++
 rtl/lsu_mem_ctrl.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/lsu_mem_if.sv
// Data-memory request/acknowledge bundle between the load/store controller and the data RAM.
// The controller uses the master side; the memory or its model uses the slave side.
interface lsu_mem_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 9
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [WIDTH-1:0]  mem_wdata;
  logic [WIDTH-1:0]  mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Multi-cycle load/store controller: issues one memory request per access, stalls the core
// until the acknowledge arrives, and formats returned load data for writeback.
module lsu_mem_ctrl #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       Opcode,
  input  logic [2:0]       Funct3,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] store_data,
  lsu_mem_if.master        mem,
  output logic [WIDTH-1:0] data_mem,
  output logic             stall,
  output logic             err
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t     state_q, state_d;
  logic       is_load, is_store, f3_ok, aligned;
  logic       access_ok, access_bad, start;
  logic [2:0] f3_q;
  logic [1:0] lane_q;
  logic       unused_addr_hi;

  assign unused_addr_hi = ^addr[WIDTH-1:ADDR_W+2];

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] lane);
    case (f3)
      3'b000:  return 4'b0001 << lane;
      3'b001:  return 4'b0011 << lane;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] store_wdata(input logic [2:0] f3,
                                                   input logic [WIDTH-1:0] sd);
    case (f3)
      3'b000:  return {(WIDTH/8){sd[7:0]}};
      3'b001:  return {(WIDTH/16){sd[15:0]}};
      default: return sd;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] load_format(input logic [WIDTH-1:0] rd,
                                                   input logic [2:0] f3,
                                                   input logic [1:0] lane);
    logic signed [7:0]       sb;
    logic signed [15:0]      sh;
    logic signed [WIDTH-1:0] ext;
    sb  = rd[{lane, 3'b000} +: 8];
    sh  = rd[{lane[1], 4'b0000} +: 16];
    ext = rd;
    case (f3)
      3'b000: ext = WIDTH'(sb);
      3'b001: ext = WIDTH'(sh);
      3'b100: ext = {{(WIDTH-8){1'b0}}, sb};
      3'b101: ext = {{(WIDTH-16){1'b0}}, sh};
      default: ext = rd;
    endcase
    return ext;
  endfunction

  // Access legality: opcode class, size/sign code and natural alignment
  always_comb begin
    is_load  = (Opcode == OP_LOAD);
    is_store = (Opcode == OP_STORE);
    f3_ok    = 1'b0;
    if (is_load)
      f3_ok = Funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    else if (is_store)
      f3_ok = Funct3 inside {3'b000, 3'b001, 3'b010};
    case (Funct3[1:0])
      2'b01:   aligned = ~addr[0];
      2'b10:   aligned = (addr[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
    access_ok  = (is_load | is_store) & f3_ok & aligned;
    access_bad = (is_load | is_store) & ~access_ok;
  end

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    start   = 1'b0;
    case (state_q)
      IDLE: begin
        if (access_ok) begin
          stall   = 1'b1;
          start   = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (mem.mem_ack) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Request capture, acknowledge handling and load writeback register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_be    <= '0;
      mem.mem_wdata <= '0;
      f3_q          <= '0;
      lane_q        <= '0;
      data_mem      <= '0;
      err           <= 1'b0;
    end else begin
      err <= (state_q == IDLE) & access_bad;
      if (start) begin
        mem.mem_req   <= 1'b1;
        mem.mem_we    <= is_store;
        mem.mem_addr  <= addr[ADDR_W+1:2];
        mem.mem_be    <= is_store ? store_be(Funct3, addr[1:0]) : 4'b1111;
        mem.mem_wdata <= store_wdata(Funct3, store_data);
        f3_q          <= Funct3;
        lane_q        <= addr[1:0];
      end
      if (state_q == BUSY && mem.mem_ack) begin
        mem.mem_req <= 1'b0;
        if (!mem.mem_we) data_mem <= load_format(mem.mem_rdata, f3_q, lane_q);
      end
    end
  end

endmodule
